// File: rtl/palette_lookup_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | palette_lookup_arbiter                                                     |
// | Shares one combinational sprite palette among NUM_REQ renderers. Lookups   |
// | take two cycles: one stage drives the palette index, one captures the RGB. |
// | Define PALETTE_ARB_RR_EN for round-robin; otherwise lowest ID wins.        |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module palette_lookup_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int IDX_W      = 4,
    parameter int TRANSP_IDX = 1
) (
    input  logic                     Clk,
    input  logic                     Reset,
    input  logic [NUM_REQ-1:0]       req,
    input  logic [NUM_REQ*IDX_W-1:0] req_index,
    output logic [NUM_REQ-1:0]       gnt,
    output logic [IDX_W-1:0]         pal_index,
    input  logic [3:0]               pal_red,
    input  logic [3:0]               pal_green,
    input  logic [3:0]               pal_blue,
    output logic                     rsp_valid,
    output logic [2:0]               rsp_id,
    output logic [3:0]               rsp_red,
    output logic [3:0]               rsp_green,
    output logic [3:0]               rsp_blue,
    output logic                     rsp_transparent,
    output logic                     busy
);

    localparam int               c_ID_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [IDX_W-1:0] c_TRANSP = IDX_W'(TRANSP_IDX);

    logic              w_found;
    logic              w_grant;
    logic [c_ID_W-1:0] w_win;
    logic [IDX_W-1:0]  w_win_index;

    logic              r_s1_valid;
    logic [c_ID_W-1:0] r_s1_id;
    logic [IDX_W-1:0]  r_pal_index;
    logic              r_rsp_valid;
    logic [2:0]        r_rsp_id;
    logic [3:0]        r_rsp_red;
    logic [3:0]        r_rsp_green;
    logic [3:0]        r_rsp_blue;
    logic              r_rsp_transparent;

`ifdef PALETTE_ARB_RR_EN
    logic [c_ID_W-1:0] r_rr_ptr;
    logic [c_ID_W-1:0] w_cand;

    // Search begins just after the last winner and wraps modulo NUM_REQ.
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        w_cand  = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            w_cand = c_ID_W'((int'(r_rr_ptr) + k) % NUM_REQ);
            if (!w_found && req[w_cand]) begin
                w_found = 1'b1;
                w_win   = w_cand;
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_rr_ptr <= c_ID_W'(NUM_REQ - 1);
        end else if (w_grant) begin
            r_rr_ptr <= w_win;
        end
    end
`else
    // Descending scan so the lowest requesting ID is the last one written.
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (req[k]) begin
                w_found = 1'b1;
                w_win   = c_ID_W'(k);
            end
        end
    end
`endif

    always_comb begin
        w_win_index = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (w_win == c_ID_W'(k)) begin
                w_win_index = req_index[k*IDX_W +: IDX_W];
            end
        end
    end

    assign w_grant = w_found && !Reset;
    assign gnt     = w_grant ? (NUM_REQ'(1) << w_win) : '0;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_s1_valid        <= 1'b0;
            r_s1_id           <= '0;
            r_pal_index       <= '0;
            r_rsp_valid       <= 1'b0;
            r_rsp_id          <= '0;
            r_rsp_red         <= '0;
            r_rsp_green       <= '0;
            r_rsp_blue        <= '0;
            r_rsp_transparent <= 1'b0;
        end else begin
            r_s1_valid <= w_grant;
            if (w_grant) begin
                r_s1_id     <= w_win;
                r_pal_index <= w_win_index;
            end
            r_rsp_valid       <= r_s1_valid;
            r_rsp_id          <= 3'(r_s1_id);
            r_rsp_red         <= pal_red;
            r_rsp_green       <= pal_green;
            r_rsp_blue        <= pal_blue;
            r_rsp_transparent <= r_s1_valid && (r_pal_index == c_TRANSP);
        end
    end

    assign pal_index       = r_pal_index;
    assign rsp_valid       = r_rsp_valid;
    assign rsp_id          = r_rsp_id;
    assign rsp_red         = r_rsp_red;
    assign rsp_green       = r_rsp_green;
    assign rsp_blue        = r_rsp_blue;
    assign rsp_transparent = r_rsp_transparent;
    assign busy            = r_s1_valid || r_rsp_valid;

endmodule
`default_nettype wire

// File: tb/tb_palette_lookup_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_palette_lookup_arbiter                                                  |
// | Directed bench with a queue-based response model and a per-cycle checker.  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_palette_lookup_arbiter;

    localparam int c_N = 4;

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic [3:0]  req = '0;
    logic [15:0] req_index = '0;
    logic [3:0]  gnt;
    logic [3:0]  pal_index;
    logic [3:0]  pal_red, pal_green, pal_blue;
    logic        rsp_valid;
    logic [2:0]  rsp_id;
    logic [3:0]  rsp_red, rsp_green, rsp_blue;
    logic        rsp_transparent;
    logic        busy;

    logic [11:0] pal_rom [16];

    int total = 0;
    int bad   = 0;

    palette_lookup_arbiter #(.NUM_REQ(4), .IDX_W(4), .TRANSP_IDX(1)) dut (
        .Clk(Clk), .Reset(Reset), .req(req), .req_index(req_index), .gnt(gnt),
        .pal_index(pal_index), .pal_red(pal_red), .pal_green(pal_green),
        .pal_blue(pal_blue), .rsp_valid(rsp_valid), .rsp_id(rsp_id),
        .rsp_red(rsp_red), .rsp_green(rsp_green), .rsp_blue(rsp_blue),
        .rsp_transparent(rsp_transparent), .busy(busy)
    );

    always #5 Clk = ~Clk;

    assign {pal_red, pal_green, pal_blue} = pal_rom[pal_index];

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {
        int due;
        int id;
        int idx;
    } exp_t;

    exp_t q[$];
    int   cyc   = 0;
    int   m_pal = 0;
    bit   m_rst = 0;
    bit   armed = 0;
`ifdef PALETTE_ARB_RR_EN
    int   m_ptr = c_N - 1;
`endif

    function automatic int model_winner(input logic [3:0] r, input logic rst);
        if (rst) return -1;
`ifdef PALETTE_ARB_RR_EN
        for (int k = 1; k <= c_N; k++) begin
            if (r[(m_ptr + k) % c_N]) return (m_ptr + k) % c_N;
        end
`else
        for (int id = 0; id < c_N; id++) begin
            if (r[id]) return id;
        end
`endif
        return -1;
    endfunction

    always begin
        int  w;
        int  wi;
        bit  ev;
        @(negedge Clk);
        #2;
        w = model_winner(req, Reset);
        if (armed) chk("gnt", int'(gnt), (w < 0) ? 0 : (1 << w));
        @(posedge Clk);
        cyc++;
        if (Reset) begin
            q.delete();
            m_pal = 0;
            m_rst = 1;
            armed = 1;
`ifdef PALETTE_ARB_RR_EN
            m_ptr = c_N - 1;
`endif
        end else begin
            m_rst = 0;
            if (w >= 0) begin
                wi = int'(req_index >> (w * 4)) & 15;
                q.push_back('{due: cyc + 1, id: w, idx: wi});
                m_pal = wi;
`ifdef PALETTE_ARB_RR_EN
                m_ptr = w;
`endif
            end
        end
        #1;
        if (armed) begin
            chk("pal_index", int'(pal_index), m_pal);
            chk("busy", int'(busy), int'(q.size() > 0));
            ev = (q.size() > 0) && (q[0].due == cyc);
            chk("rsp_valid", int'(rsp_valid), int'(ev));
            if (ev) begin
                chk("rsp_id", int'(rsp_id), q[0].id);
                chk("rsp_rgb", int'({rsp_red, rsp_green, rsp_blue}), int'(pal_rom[q[0].idx]));
                chk("rsp_transparent", int'(rsp_transparent), int'(q[0].idx == 1));
                void'(q.pop_front());
            end else begin
                chk("idle_transparent", int'(rsp_transparent), 0);
                if (m_rst) begin
                    chk("reset_rsp_id", int'(rsp_id), 0);
                    chk("reset_rsp_rgb", int'({rsp_red, rsp_green, rsp_blue}), 0);
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic step(input logic rst, input logic [3:0] r, input logic [15:0] idx);
        @(negedge Clk);
        Reset     = rst;
        req       = r;
        req_index = idx;
    endtask

    initial begin
        logic [3:0] exp_g [4];
        for (int i = 0; i < 16; i++) pal_rom[i] = {4'(i), 4'(15 - i), 4'(i ^ 9)};
        pal_rom[3] = 12'hB0B;
        pal_rom[1] = 12'hAEA;

        repeat (3) step(1'b1, 4'b0000, 16'h0000);

        // requester 2 alone, index 3
        step(1'b0, 4'b0100, 16'h0300);
        #2 chk("lit_gnt_r2", int'(gnt), 4);
        @(posedge Clk); #1 chk("lit_pal_index_3", int'(pal_index), 3);
        step(1'b0, 4'b0000, 16'h0000);
        @(posedge Clk); #1;
        chk("lit_rsp_valid", int'(rsp_valid), 1);
        chk("lit_rsp_id_2", int'(rsp_id), 2);
        chk("lit_rgb_B0B", int'({rsp_red, rsp_green, rsp_blue}), 12'hB0B);
        chk("lit_opaque", int'(rsp_transparent), 0);
        step(1'b0, 4'b0000, 16'h0000);

        // requester 0 with the transparent key index
        step(1'b0, 4'b0001, 16'h0001);
        #2 chk("lit_gnt_r0", int'(gnt), 1);
        step(1'b0, 4'b0000, 16'h0000);
        @(posedge Clk); #1;
        chk("lit_transparent", int'(rsp_transparent), 1);
        chk("lit_rgb_AEA", int'({rsp_red, rsp_green, rsp_blue}), 12'hAEA);
        step(1'b0, 4'b0000, 16'h0000);

        // all four requesting continuously from a fresh reset
        step(1'b1, 4'b0000, 16'h0000);
`ifdef PALETTE_ARB_RR_EN
        exp_g = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
`else
        exp_g = '{4'b0001, 4'b0001, 4'b0001, 4'b0001};
`endif
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 4'b1111, 16'h7654);
            #2 chk("lit_gnt_all", int'(gnt), int'(exp_g[i % 4]));
        end

        // requesters 1 and 3 together
`ifdef PALETTE_ARB_RR_EN
        exp_g = '{4'b0010, 4'b1000, 4'b0010, 4'b1000};
`else
        exp_g = '{4'b0010, 4'b0010, 4'b0010, 4'b0010};
`endif
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 4'b1010, 16'h9080);
            #2 chk("lit_gnt_1_3", int'(gnt), int'(exp_g[i]));
        end
        repeat (2) step(1'b0, 4'b0000, 16'h0000);

        // reset while lookups are in flight, requests still asserted
        step(1'b0, 4'b0011, 16'h00DC);
        step(1'b0, 4'b0011, 16'h00DC);
        step(1'b1, 4'b0011, 16'h00DC);
        #2 chk("lit_gnt_in_reset", int'(gnt), 0);
        @(posedge Clk); #1;
        chk("lit_reset_valid", int'(rsp_valid), 0);
        chk("lit_reset_busy", int'(busy), 0);
        chk("lit_reset_pal_index", int'(pal_index), 0);
        step(1'b0, 4'b0011, 16'h00DC);
        #2 chk("lit_gnt_after_reset", int'(gnt), 1);
        repeat (3) step(1'b0, 4'b0000, 16'h0000);

        // bursts separated by one idle cycle
        step(1'b0, 4'b0100, 16'h0A00);
        step(1'b0, 4'b0100, 16'h0A00);
        step(1'b0, 4'b0000, 16'h0000);
        @(posedge Clk); #1 chk("lit_pal_hold", int'(pal_index), 10);
        step(1'b0, 4'b1000, 16'hF000);
        step(1'b0, 4'b1000, 16'hF000);
        repeat (4) step(1'b0, 4'b0000, 16'h0000);

        @(posedge Clk); #3;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
